// File: rtl/mem_access_unit_pkg.sv
// Shared ISA constants for the memory access path: access modes, widths,
// FSM state encodings and the alignment rule for requests.
package mem_access_unit_pkg;

  localparam int MODE_W = 2;
  localparam int WORD_W = 32;

  typedef logic [MODE_W-1:0] mem_mode_t;

  localparam mem_mode_t MEM_BYTE = 2'b00;
  localparam mem_mode_t MEM_HALF = 2'b01;
  localparam mem_mode_t MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // A request is illegal when it is misaligned for its size or uses the
  // reserved mode encoding.
  function automatic logic req_is_illegal(input mem_mode_t mode, input logic [1:0] addr_lo);
    case (mode)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return (addr_lo != 2'b00);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle and memory bus bundle. The requester
// (or bus owner) uses master; the unit (or memory) uses slave.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  mem_mode_t         req_mode;
  logic              req_signed;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_write, req_mode, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_mode, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

interface mem_bus_if;
  import mem_access_unit_pkg::*;

  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_writeData;
  mem_mode_t         mem_mode;
  logic              mem_memRead;
  logic              mem_memWrite;
  logic [WORD_W-1:0] mem_readData;

  modport master (
    output mem_address, mem_writeData, mem_mode, mem_memRead, mem_memWrite,
    input  mem_readData
  );

  modport slave (
    input  mem_address, mem_writeData, mem_mode, mem_memRead, mem_memWrite,
    output mem_readData
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load extension: the memory returns the selected byte/half zero-extended in
// the low bits; this widens it to a word, optionally sign-extending.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  mem_mode_t         mode,
  input  logic              sign_ext,
  output logic [WORD_W-1:0] result
);

  // Pick the sign source bit by access size; words pass through untouched
  always_comb begin
    result = data;
    case (mode)
      MEM_BYTE: result = {{24{sign_ext & data[7]}}, data[7:0]};
      MEM_HALF: result = {{16{sign_ext & data[15]}}, data[15:0]};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between a valid/ready requester and a
// big-endian memory with combinational reads and negedge writes.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_access_unit_if.slave req_if,
  mem_bus_if.master        mem_if
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  mem_mode_t         mode_q, mode_d;
  logic              write_q, write_d;
  logic              signed_q, signed_d;
  logic              fault_q, fault_d;

  logic              accept;
  logic              illegal;
  logic [WORD_W-1:0] load_data;

  // Requests are only taken in IDLE; anything presented elsewhere waits
  assign accept  = (state_q == IDLE) && req_if.req_valid;
  assign illegal = req_is_illegal(req_if.req_mode, req_if.req_addr[1:0]);

  load_extend u_load_extend (
    .data     (mem_if.mem_readData),
    .mode     (mode_q),
    .sign_ext (signed_q),
    .result   (load_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: faults skip ACCESS so no memory strobe is ever issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = illegal ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP: begin
        if (req_if.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch legal requests, capture load data as ACCESS ends
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mode_d   = mode_q;
    write_d  = write_q;
    signed_d = signed_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    if (accept) begin
      rdata_d = '0;
      fault_d = illegal;
      if (!illegal) begin
        addr_d   = req_if.req_addr;
        wdata_d  = req_if.req_wdata;
        mode_d   = req_if.req_mode;
        write_d  = req_if.req_write;
        signed_d = req_if.req_signed;
      end
    end
    if (state_q == ACCESS) begin
      rdata_d = write_q ? '0 : load_data;
    end
  end

  // Datapath registers; mode resets to WORD so the idle bus looks like a word access
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= MEM_WORD;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mode_q   <= mode_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Outputs decoded from state; strobes exist only during ACCESS
  always_comb begin
    req_if.req_ready     = (state_q == IDLE);
    req_if.resp_valid    = (state_q == RESP);
    req_if.resp_rdata    = rdata_q;
    req_if.resp_fault    = fault_q;
    mem_if.mem_address   = addr_q;
    mem_if.mem_writeData = wdata_q;
    mem_if.mem_mode      = mode_q;
    mem_if.mem_memRead   = (state_q == ACCESS) && !write_q;
    mem_if.mem_memWrite  = (state_q == ACCESS) && write_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if rq();
  mem_bus_if         mb();

  mem_access_unit dut (
    .clk    (clk),
    .reset  (reset),
    .req_if (rq),
    .mem_if (mb)
  );

  // Big-endian byte memory model
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma = mb.mem_address[9:0];

  always_comb begin
    mb.mem_readData = 32'h0;
    case (mb.mem_mode)
      MEM_BYTE: mb.mem_readData = {24'h0, mem[ma]};
      MEM_HALF: mb.mem_readData = {16'h0, mem[ma], mem[ma + 10'd1]};
      default:  mb.mem_readData = {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};
    endcase
  end

  int n_compared   = 0;
  int n_mismatched = 0;
  int rd_strobes   = 0;
  int wr_strobes   = 0;
  int both_strobes = 0;

  always @(negedge clk) begin
    if (mb.mem_memRead) rd_strobes++;
    if (mb.mem_memRead && mb.mem_memWrite) both_strobes++;
    if (mb.mem_memWrite) begin
      wr_strobes++;
      case (mb.mem_mode)
        MEM_BYTE: mem[ma] = mb.mem_writeData[7:0];
        MEM_HALF: begin
          mem[ma]         = mb.mem_writeData[15:8];
          mem[ma + 10'd1] = mb.mem_writeData[7:0];
        end
        default: begin
          mem[ma]         = mb.mem_writeData[31:24];
          mem[ma + 10'd1] = mb.mem_writeData[23:16];
          mem[ma + 10'd2] = mb.mem_writeData[15:8];
          mem[ma + 10'd3] = mb.mem_writeData[7:0];
        end
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request and return just after its acceptance edge
  task automatic issue(input logic w, input logic [1:0] m, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    check_eq("ready_before_req", 32'(rq.req_ready), 32'd1);
    rq.req_valid  = 1'b1;
    rq.req_write  = w;
    rq.req_mode   = m;
    rq.req_signed = s;
    rq.req_addr   = a;
    rq.req_wdata  = d;
    @(posedge clk); #1;
    rq.req_valid  = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!rq.resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rq.resp_valid) check_eq("resp_timeout", 32'(rq.resp_valid), 32'd1);
  endtask

  task automatic ack();
    rq.resp_ready = 1'b1;
    @(posedge clk); #1;
    rq.resp_ready = 1'b0;
    check_eq("idle_after_ack", 32'(rq.req_ready), 32'd1);
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] m, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
    int r0, w0, lat;
    r0 = rd_strobes;
    w0 = wr_strobes;
    issue(w, m, s, a, d);
    wait_resp(lat);
    check_eq({tag, "_rdata"}, rq.resp_rdata, exp_rdata);
    check_eq({tag, "_fault"}, 32'(rq.resp_fault), 32'(exp_fault));
    check_eq({tag, "_latency"}, lat, exp_lat);
    $display("txn %s w=%0d mode=%0d addr=0x%08h rdata=0x%08h fault=%0d lat=%0d",
             tag, w, m, a, rq.resp_rdata, rq.resp_fault, lat);
    ack();
    check_eq({tag, "_rd_strobes"}, rd_strobes - r0, (exp_fault || w) ? 0 : 1);
    check_eq({tag, "_wr_strobes"}, wr_strobes - w0, (!exp_fault && w) ? 1 : 0);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset         = 1'b1;
    rq.req_valid  = 1'b0;
    rq.req_write  = 1'b0;
    rq.req_mode   = MEM_WORD;
    rq.req_signed = 1'b0;
    rq.req_addr   = 32'h0;
    rq.req_wdata  = 32'h0;
    rq.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(rq.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(rq.resp_valid), 32'd0);
    check_eq("rst_mem_mode", 32'(mb.mem_mode), 32'(MEM_WORD));
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_resp_fault", 32'(rq.resp_fault), 32'd0);
    check_eq("rst_resp_rdata", rq.resp_rdata, 32'h0);
    check_eq("rst_mem_read", 32'(mb.mem_memRead), 32'd0);
    check_eq("rst_mem_write", 32'(mb.mem_memWrite), 32'd0);
    check_eq("rst_mem_addr", mb.mem_address, 32'h0);

    // Store/load round trip and sub-word loads
    do_req("sw_100", 1'b1, MEM_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check_eq("mem_after_sw", {mem[256], mem[257], mem[258], mem[259]}, 32'hDEADBEEF);
    do_req("lw_100", 1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    do_req("lb_101", 1'b0, MEM_BYTE, 1'b1, 32'h101, 32'h0, 32'hFFFFFFAD, 1'b0, 2);
    do_req("lbu_101", 1'b0, MEM_BYTE, 1'b0, 32'h101, 32'h0, 32'h000000AD, 1'b0, 2);
    do_req("lh_102", 1'b0, MEM_HALF, 1'b1, 32'h102, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    do_req("lhu_102", 1'b0, MEM_HALF, 1'b0, 32'h102, 32'h0, 32'h0000BEEF, 1'b0, 2);
    do_req("lw_signed", 1'b0, MEM_WORD, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Sub-word stores take only the low byte/half of wdata
    do_req("sb_104", 1'b1, MEM_BYTE, 1'b0, 32'h104, 32'h12345678, 32'h0, 1'b0, 2);
    do_req("sh_106", 1'b1, MEM_HALF, 1'b0, 32'h106, 32'h9876CAFE, 32'h0, 1'b0, 2);
    do_req("lw_104", 1'b0, MEM_WORD, 1'b0, 32'h104, 32'h0, 32'h7800CAFE, 1'b0, 2);
    do_req("lb_104_pos", 1'b0, MEM_BYTE, 1'b1, 32'h104, 32'h0, 32'h00000078, 1'b0, 2);
    do_req("lh_106", 1'b0, MEM_HALF, 1'b1, 32'h106, 32'h0, 32'hFFFFCAFE, 1'b0, 2);

    // Faults: no strobes, memory untouched, one-cycle latency
    do_req("lw_102_fault", 1'b0, MEM_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    do_req("sh_101_fault", 1'b1, MEM_HALF, 1'b0, 32'h101, 32'h00001234, 32'h0, 1'b1, 1);
    do_req("sw_101_fault", 1'b1, MEM_WORD, 1'b0, 32'h101, 32'h11111111, 32'h0, 1'b1, 1);
    do_req("mode3_fault", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    check_eq("mem_unchanged", {mem[256], mem[257], mem[258], mem[259]}, 32'hDEADBEEF);
    do_req("after_fault", 1'b0, MEM_HALF, 1'b0, 32'h100, 32'h0, 32'h0000DEAD, 1'b0, 2);

    // Response backpressure
    issue(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0);
    wait_resp(lat);
    check_eq("bp_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(rq.resp_valid), 32'd1);
      check_eq("bp_rdata", rq.resp_rdata, 32'hDEADBEEF);
      check_eq("bp_fault", 32'(rq.resp_fault), 32'd0);
      check_eq("bp_req_ready", 32'(rq.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    $display("txn backpressure rdata=0x%08h held 5 cycles", rq.resp_rdata);
    ack();
    check_eq("bp_valid_after", 32'(rq.resp_valid), 32'd0);

    // Reset in the ACCESS cycle of a load
    issue(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0);
    check_eq("acc_mem_read", 32'(mb.mem_memRead), 32'd1);
    reset = 1'b1;
    rq.resp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rq.resp_ready = 1'b0;
    check_eq("rst_acc_req_ready", 32'(rq.req_ready), 32'd1);
    check_eq("rst_acc_resp_valid", 32'(rq.resp_valid), 32'd0);
    check_eq("rst_acc_rdata", rq.resp_rdata, 32'h0);
    check_eq("rst_acc_fault", 32'(rq.resp_fault), 32'd0);
    check_eq("rst_acc_mem_read", 32'(mb.mem_memRead), 32'd0);
    check_eq("rst_acc_mem_addr", mb.mem_address, 32'h0);
    check_eq("rst_acc_mem_mode", 32'(mb.mem_mode), 32'(MEM_WORD));
    $display("txn reset_during_load_access");
    do_req("lw_after_rst", 1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Reset in the ACCESS cycle of a store: the negedge write already happened
    issue(1'b1, MEM_WORD, 1'b0, 32'h108, 32'hA5A5A5A5);
    check_eq("acc_mem_write", 32'(mb.mem_memWrite), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_st_mem_write", 32'(mb.mem_memWrite), 32'd0);
    check_eq("rst_st_resp_valid", 32'(rq.resp_valid), 32'd0);
    check_eq("rst_st_committed", {mem[264], mem[265], mem[266], mem[267]}, 32'hA5A5A5A5);
    $display("txn reset_during_store_access");

    check_eq("never_both_strobes", both_strobes, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
